rv_io_uart_mc: RTL and testbench
================================

# rv_io_uart_mc

Multi-channel IO UART for the RVOOM IO switch: NCH independent 8N1 UARTs behind one addr/data request port, each with its own TX and RX FIFOs, baud divisor and interrupt enables. It replaces the single 16550-wrapper UART slot with a self-contained, parametrised block. It speaks the same addr_req/addr_ack, data_req/data_ack split transaction as the other IO slaves.

## Interface
- RV, 64: data bus width.
- NCH, 2: channel count, 1..8.
- FIFO_DEPTH, 16: entries per TX/RX FIFO, power of two, ≥2.
- DIV_RESET, 16'd26: divisor reset value.
- clk  in  1  core clock.
- reset_n  in  1  reset, asynchronous, active-low.
- addr_req  in  1  address-phase request.
- addr_ack  out  1  address-phase accept, one-cycle pulse.
- sel  in  1  slot select; request ignored when 0.
- addr  in  12  byte address; channel = addr[6+:3], register = addr[5:3].
- read  in  1  1 = read, 0 = write.
- mask  in  8  byte enables; byte 0 must be set for a write to take effect.
- wdata  in  RV  write data; bits [15:0] used.
- data_req  out  1  read data valid.
- data_ack  in  1  read data consumed.
- rdata  out  RV  read data, zero-extended from 16 bits.
- interrupt  out  1  OR of all channel interrupts.
- tx  out  NCH  serial out, idle high.
- rx  in  NCH  serial in, asynchronous.
- rts  out  NCH  request-to-send, 1 = receiver may accept.
- cts  in  NCH  clear-to-send, 1 = remote may accept.

## Operation
- Registers (reg index):
  - 0 DATA: write pushes the TX FIFO. Read pops the RX FIFO; returns 0 with no pop when empty.
  - 1 STATUS (RO except W1C): [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_idle, [5] rx_overrun sticky, [6] frame_err sticky, [7] tx_overflow sticky. Write 1 to clear bits 5–7.
  - 2 CTRL: [0] tx_en, [1] rx_en, [2] ie_rx, [3] ie_txempty, [4] ie_err, [5] flow_en. Reset value 0.
  - 3 DIV: 16-bit divisor.
  - 4 LEVEL (RO): [7:0] RX count, [15:8] TX count.
  - 5–7: read 0, writes ignored.
- Channel index ≥ NCH: acked; reads return 0; writes ignored.
- Baud: per-channel counter produces tick every DIV+1 cycles; 16 ticks per bit.
- TX FSM states IDLE, START, DATA(8, LSB first), STOP.
  - IDLE→START when tx_en, FIFO nonempty and (flow off or cts=1).
  - cts is sampled only in IDLE; a frame in progress always completes.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - RX FSM: IDLE→START on falling edge, when rx_en.
  - START: re-sampled at tick 8; if high, return to IDLE (glitch).
  - DATA samples at mid-bit, then STOP.
  - Stop bit = 0: set frame_err, drop the byte.
  - Push to a full RX FIFO: set rx_overrun, drop the byte.
- TX write to a full FIFO: set tx_overflow, drop the byte.
- FIFO push and pop in the same cycle are both honoured; count is unchanged.
- Channel irq = (ie_rx & rx_nonempty) | (ie_txempty & tx_empty & tx_idle) | (ie_err & any sticky bit).
- interrupt is a registered OR of all channel irqs.

## Timing
- Request accepted when addr_req & sel & !data_req & !r_backoff.
  - addr_ack pulses the cycle after acceptance.
  - The register side effect (push, pop, write) occurs in that same cycle.
- The backoff flop blocks re-acceptance in the cycle after addr_ack.
- Reads: data_req rises the cycle after addr_ack.
  - rdata is held stable until the cycle data_ack is seen high.
  - data_req falls the following cycle.
- Writes produce no data phase.
- Reset values: addr_ack 0, data_req 0, rdata 0, interrupt 0, tx all 1, rts all 0, FIFOs empty, DIV=DIV_RESET.
- Reset asserted mid-frame forces tx high asynchronously.
- TX frame length: 160·(DIV+1) cycles from START entry to IDLE.

## Configuration
- RV_UART_FLOW_EN defined:
  - rts = flow_en & (RX count < FIFO_DEPTH-1).
  - cts gates TX start.
- Undefined:
  - rts tied 0.
  - cts ignored.
  - CTRL[5] reads 0.

## Structure
- Package rv_uart_pkg holds:
  - register index localparams;
  - STATUS/CTRL bit positions;
  - TX/RX state enums.
- Sub-module rv_uart_chan (one per channel, generate loop) holds the divisor, both FSMs, both FIFOs and the sticky bits.
- The top level keeps only decode, handshake and read mux.

## Test plan
- Write DIV=3, CTRL=0x01, DATA=0x55 on ch0 -> tx[0] frame 0,1,0,1,0,1,0,1,0,1, each bit 64 cycles; STATUS[4] returns to 1.
- Loop tx[1]→rx[1], CTRL=0x07, send 0xA3 -> interrupt rises; DATA read returns 0xA3; LEVEL[7:0] goes 1→0.
- Write 17 bytes with tx_en=0, FIFO_DEPTH=16 -> LEVEL[15:8]=16, STATUS[7]=1; write STATUS=0x80 clears it.
- Drive rx with stop bit 0 -> STATUS[6]=1, no push.
- Receive 17 bytes unread -> STATUS[5]=1.
- Read with data_ack held low 10 cycles -> data_req and rdata stable; no second addr_ack during that time.
- Pulse reset_n low mid-frame -> tx=1 immediately, all registers at reset values.

Source files
------------

// File: rtl/rv_uart_pkg.sv
// rtl/rv_uart_pkg.sv - register map, status/ctrl bit positions and FSM states for the multi-channel UART
package rv_uart_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_DIV    = 3'd3;
  localparam logic [2:0] REG_LEVEL  = 3'd4;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_RX_FULL     = 1;
  localparam int ST_TX_EMPTY    = 2;
  localparam int ST_TX_FULL     = 3;
  localparam int ST_TX_IDLE     = 4;
  localparam int ST_RX_OVERRUN  = 5;
  localparam int ST_FRAME_ERR   = 6;
  localparam int ST_TX_OVERFLOW = 7;

  localparam int CT_TX_EN      = 0;
  localparam int CT_RX_EN      = 1;
  localparam int CT_IE_RX      = 2;
  localparam int CT_IE_TXEMPTY = 3;
  localparam int CT_IE_ERR     = 4;
  localparam int CT_FLOW_EN    = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/rv_uart_chan.sv
// rtl/rv_uart_chan.sv - one 8N1 UART channel: divisor, TX/RX FSMs, FIFOs, sticky errors (RV_UART_FLOW_EN adds RTS/CTS)
module rv_uart_chan
  import rv_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd26
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_stb,
  input  logic        rd_stb,
  input  logic        wr_en,
  input  logic [2:0]  reg_idx,
  input  logic [15:0] wdata,
  output logic [15:0] rd_val,
  output logic        irq,
  output logic        tx,
  input  logic        rx,
  output logic        rts,
  input  logic        cts
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [5:0]  ctrl;
  logic [15:0] div;
  logic        st_overrun, st_frame_err, st_tx_ovf;
  logic [7:0]  status;

  logic        do_wr, tx_push_req, tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;

  logic        rx_push, rx_pop, rx_full, rx_nonempty;
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;

  tx_state_t   tx_state, tx_next;
  logic        tx_load, tx_tick, cts_ok;
  logic [15:0] tx_baud;
  logic [3:0]  tx_sub;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  rx_state_t   rx_state, rx_next;
  logic        rx_done, rx_tick;
  logic        rx_meta, rx_s, rx_prev;
  logic [15:0] rx_baud;
  logic [3:0]  rx_sub;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  assign do_wr       = wr_stb & wr_en;
  assign tx_push_req = do_wr && (reg_idx == REG_DATA);
  assign tx_full     = (tx_cnt == CW'(FIFO_DEPTH));
  assign tx_empty    = (tx_cnt == '0);
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = tx_load;

  assign rx_full     = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_nonempty = (rx_cnt != '0);
  assign rx_push     = rx_done & rx_s & ~rx_full;
  assign rx_pop      = rd_stb && (reg_idx == REG_DATA) && rx_nonempty;

  assign tx_tick = (tx_baud >= div);
  assign rx_tick = (rx_baud >= div);

`ifdef RV_UART_FLOW_EN
  assign cts_ok = ~ctrl[CT_FLOW_EN] | cts;
  assign rts    = ctrl[CT_FLOW_EN] & (rx_cnt < CW'(FIFO_DEPTH - 1));
`else
  logic unused_cts;
  assign unused_cts = cts;
  assign cts_ok     = 1'b1;
  assign rts        = 1'b0;
`endif

  // FIFO storage is not reset; occupancy is tracked by the counters below
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  // FIFO pointers and counts; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      tx_wp  <= tx_wp + AW'(tx_push);
      tx_rp  <= tx_rp + AW'(tx_pop);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_wp  <= rx_wp + AW'(rx_push);
      rx_rp  <= rx_rp + AW'(rx_pop);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Control/divisor writes and sticky error bits (set has priority over write-1-to-clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl         <= '0;
      div          <= DIV_RESET;
      st_overrun   <= 1'b0;
      st_frame_err <= 1'b0;
      st_tx_ovf    <= 1'b0;
    end else begin
      if (do_wr && reg_idx == REG_CTRL) begin
`ifdef RV_UART_FLOW_EN
        ctrl <= wdata[5:0];
`else
        ctrl <= {1'b0, wdata[4:0]};
`endif
      end
      if (do_wr && reg_idx == REG_DIV) div <= wdata;
      if (do_wr && reg_idx == REG_STATUS) begin
        if (wdata[ST_RX_OVERRUN])  st_overrun   <= 1'b0;
        if (wdata[ST_FRAME_ERR])   st_frame_err <= 1'b0;
        if (wdata[ST_TX_OVERFLOW]) st_tx_ovf    <= 1'b0;
      end
      if (tx_push_req && tx_full) st_tx_ovf <= 1'b1;
      if (rx_done && !rx_s) st_frame_err <= 1'b1;
      if (rx_done && rx_s && rx_full) st_overrun <= 1'b1;
    end
  end

  // TX and RX state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  // TX next state: cts only matters before a frame starts
  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE: if (ctrl[CT_TX_EN] && !tx_empty && cts_ok) begin
        tx_next = TX_START;
        tx_load = 1'b1;
      end
      TX_START: if (tx_tick && tx_sub == 4'd15) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_sub == 4'd15 && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick && tx_sub == 4'd15) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX baud/bit counters restart at frame start so a frame is exactly 160 ticks long
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_baud <= '0; tx_sub <= '0; tx_bit <= '0; tx_shift <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_baud <= '0; tx_sub <= '0; tx_bit <= '0;
      if (tx_load) tx_shift <= tx_mem[tx_rp];
    end else if (tx_tick) begin
      tx_baud <= '0;
      tx_sub  <= tx_sub + 4'd1;
      if (tx_state == TX_DATA && tx_sub == 4'd15) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + 3'd1;
      end
    end else begin
      tx_baud <= tx_baud + 16'd1;
    end
  end

  assign tx = (tx_state == TX_START) ? 1'b0 :
              (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

  // rx synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1; rx_s <= 1'b1; rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx; rx_s <= rx_meta; rx_prev <= rx_s;
    end
  end

  // RX next state: start bit re-checked at mid-bit, then every 16 ticks lands mid-bit
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      RX_IDLE:  if (ctrl[CT_RX_EN] && rx_prev && !rx_s) rx_next = RX_START;
      RX_START: if (rx_tick && rx_sub == 4'd7) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_sub == 4'd15 && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick && rx_sub == 4'd15) begin
        rx_next = RX_IDLE;
        rx_done = 1'b1;
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX baud/bit counters and LSB-first shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_baud <= '0; rx_sub <= '0; rx_bit <= '0; rx_shift <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_baud <= '0; rx_sub <= '0; rx_bit <= '0;
    end else if (rx_tick) begin
      rx_baud <= '0;
      rx_sub  <= (rx_state == RX_START && rx_sub == 4'd7) ? 4'd0 : rx_sub + 4'd1;
      if (rx_state == RX_DATA && rx_sub == 4'd15) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end else begin
      rx_baud <= rx_baud + 16'd1;
    end
  end

  // status word assembled from the package bit positions
  always_comb begin
    status                 = '0;
    status[ST_RX_NONEMPTY] = rx_nonempty;
    status[ST_RX_FULL]     = rx_full;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_TX_IDLE]     = (tx_state == TX_IDLE);
    status[ST_RX_OVERRUN]  = st_overrun;
    status[ST_FRAME_ERR]   = st_frame_err;
    status[ST_TX_OVERFLOW] = st_tx_ovf;
  end

  assign irq = (ctrl[CT_IE_RX] & rx_nonempty) |
               (ctrl[CT_IE_TXEMPTY] & tx_empty & (tx_state == TX_IDLE)) |
               (ctrl[CT_IE_ERR] & (st_overrun | st_frame_err | st_tx_ovf));

  // register read value, sampled by the top before any pop takes effect
  always_comb begin
    rd_val = 16'h0;
    case (reg_idx)
      REG_DATA:   if (rx_nonempty) rd_val = {8'h00, rx_mem[rx_rp]};
      REG_STATUS: rd_val = {8'h00, status};
      REG_CTRL:   rd_val = {10'h000, ctrl};
      REG_DIV:    rd_val = div;
      REG_LEVEL:  rd_val = {8'(tx_cnt), 8'(rx_cnt)};
      default:    rd_val = 16'h0;
    endcase
  end

endmodule

// File: rtl/rv_io_uart_mc.sv
// rtl/rv_io_uart_mc.sv - multi-channel UART IO slave: decode, split handshake, read mux (RV_UART_FLOW_EN enables RTS/CTS)
module rv_io_uart_mc
  import rv_uart_pkg::*;
#(
  parameter int          RV         = 64,
  parameter int          NCH        = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd26
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           addr_req,
  output logic           addr_ack,
  input  logic           sel,
  input  logic [11:0]    addr,
  input  logic           read,
  input  logic [7:0]     mask,
  input  logic [RV-1:0]  wdata,
  output logic           data_req,
  input  logic           data_ack,
  output logic [RV-1:0]  rdata,
  output logic           interrupt,
  output logic [NCH-1:0] tx,
  input  logic [NCH-1:0] rx,
  output logic [NCH-1:0] rts,
  input  logic [NCH-1:0] cts
);

  logic           accept, r_backoff, r_read, r_we;
  logic [2:0]     r_ch, r_reg;
  logic [15:0]    r_wdata, rd_mux;
  logic [15:0]    chan_rd [NCH];
  logic [NCH-1:0] chan_irq;

  logic unused_bits;
  assign unused_bits = ^{wdata[RV-1:16], mask[7:1], addr[11:9], addr[2:0]};

  // the ack cycle is blocked too, so a master still holding addr_req is not accepted twice
  assign accept = addr_req & sel & ~data_req & ~addr_ack & ~r_backoff;

  // address phase: capture request, pulse ack, then back off for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_ack  <= 1'b0;
      r_backoff <= 1'b0;
      r_read    <= 1'b0;
      r_we      <= 1'b0;
      r_ch      <= '0;
      r_reg     <= '0;
      r_wdata   <= '0;
    end else begin
      addr_ack  <= accept;
      r_backoff <= addr_ack;
      if (accept) begin
        r_read  <= read;
        r_we    <= mask[0];
        r_ch    <= addr[8:6];
        r_reg   <= addr[5:3];
        r_wdata <= wdata[15:0];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    rv_uart_chan #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .DIV_RESET (DIV_RESET)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .wr_stb (addr_ack & ~r_read & (r_ch == 3'(g))),
      .rd_stb (addr_ack &  r_read & (r_ch == 3'(g))),
      .wr_en  (r_we),
      .reg_idx(r_reg),
      .wdata  (r_wdata),
      .rd_val (chan_rd[g]),
      .irq    (chan_irq[g]),
      .tx     (tx[g]),
      .rx     (rx[g]),
      .rts    (rts[g]),
      .cts    (cts[g])
    );
  end

  // channels at or above NCH fall through to zero
  always_comb begin
    rd_mux = 16'h0;
    for (int i = 0; i < NCH; i++) begin
      if (r_ch == 3'(i)) rd_mux = chan_rd[i];
    end
  end

  // data phase: rdata held until data_ack, data_req drops the cycle after
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_req <= 1'b0;
      rdata    <= '0;
    end else if (addr_ack && r_read) begin
      data_req <= 1'b1;
      rdata    <= {{(RV-16){1'b0}}, rd_mux};
    end else if (data_req && data_ack) begin
      data_req <= 1'b0;
    end
  end

  // registered OR of channel interrupts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) interrupt <= 1'b0;
    else          interrupt <= |chan_irq;
  end

endmodule

// File: tb/tb_rv_io_uart_mc.sv
// tb/tb_rv_io_uart_mc.sv - directed self-checking bench for rv_io_uart_mc
module tb_rv_io_uart_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        addr_req = 1'b0;
  logic        addr_ack;
  logic        sel = 1'b0;
  logic [11:0] addr = '0;
  logic        read = 1'b0;
  logic [7:0]  mask = '0;
  logic [63:0] wdata = '0;
  logic        data_req;
  logic        data_ack = 1'b0;
  logic [63:0] rdata;
  logic        interrupt;
  logic [1:0]  tx;
  logic [1:0]  rx;
  logic [1:0]  rts;
  logic [1:0]  cts = 2'b11;
  logic        rx0 = 1'b1;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  assign rx = {tx[1], rx0};

  always #5 clk = ~clk;

  rv_io_uart_mc #(
    .RV(64), .NCH(2), .FIFO_DEPTH(16), .DIV_RESET(16'd26)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .addr_req(addr_req), .addr_ack(addr_ack), .sel(sel), .addr(addr),
    .read(read), .mask(mask), .wdata(wdata),
    .data_req(data_req), .data_ack(data_ack), .rdata(rdata),
    .interrupt(interrupt), .tx(tx), .rx(rx), .rts(rts), .cts(cts)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input string tag, input int ch, input int r, input logic rd,
                            input logic [7:0] m, input logic [15:0] d);
    int n;
    @(posedge clk); #1;
    addr_req = 1'b1; sel = 1'b1; read = rd; mask = m;
    addr = {3'b000, 3'(ch), 3'(r), 3'b000};
    wdata = {48'h0, d};
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!addr_ack && n < 20);
    check({tag, "/ack"}, {63'h0, addr_ack}, 64'h1);
    addr_req = 1'b0;
  endtask

  task automatic wr(input string tag, input int ch, input int r, input logic [15:0] d);
    addr_phase(tag, ch, r, 1'b0, 8'h01, d);
  endtask

  task automatic rd_chk(input string tag, input int ch, input int r, input logic [63:0] exp);
    int n;
    addr_phase(tag, ch, r, 1'b1, 8'h00, 16'h0);
    n = 0;
    while (!data_req && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check(tag, data_req ? rdata : 64'hBAD0_BAD0_BAD0_BAD0, exp);
    data_ack = 1'b1;
    @(posedge clk); #1;
    data_ack = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx0 = f[k];
      repeat (16) @(posedge clk);
    end
    rx0 = 1'b1;
    repeat (16) @(posedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] f;
    int n;

    // reset state
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    check("rst/addr_ack", {63'h0, addr_ack}, 64'h0);
    check("rst/data_req", {63'h0, data_req}, 64'h0);
    check("rst/rdata", rdata, 64'h0);
    check("rst/interrupt", {63'h0, interrupt}, 64'h0);
    check("rst/tx", {62'h0, tx}, 64'h3);
    check("rst/rts", {62'h0, rts}, 64'h0);
    rd_chk("rst/div", 0, 3, 64'h1A);
    rd_chk("rst/status", 0, 1, 64'h14);

    // ch0 transmits 0x55 at DIV=3: 64 cycles per bit
    wr("t1/div", 0, 3, 16'd3);
    wr("t1/ctrl", 0, 2, 16'h01);
    wr("t1/data", 0, 0, 16'h55);
    n = 0;
    while (tx[0] !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("t1/start_seen", {63'h0, tx[0]}, 64'h0);
    f = {1'b1, 8'h55, 1'b0};
    cyc(32);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t1/bit%0d", k), {63'h0, tx[0]}, {63'h0, f[k]});
      cyc(64);
    end
    rd_chk("t1/status_idle", 0, 1, 64'h14);

    // ch1 loopback with rx interrupt
    wr("t2/div", 1, 3, 16'd0);
    wr("t2/ctrl", 1, 2, 16'h07);
    check("t2/irq_low", {63'h0, interrupt}, 64'h0);
    wr("t2/data", 1, 0, 16'hA3);
    n = 0;
    while (!interrupt && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("t2/irq_rise", {63'h0, interrupt}, 64'h1);
    rd_chk("t2/level1", 1, 4, 64'h0001);
    rd_chk("t2/data", 1, 0, 64'hA3);
    rd_chk("t2/level0", 1, 4, 64'h0000);
    check("t2/irq_fall", {63'h0, interrupt}, 64'h0);
    rd_chk("t2/data_empty", 1, 0, 64'h0);
    addr_phase("t2/masked", 1, 3, 1'b0, 8'h00, 16'h0055);
    rd_chk("t2/div_unchanged", 1, 3, 64'h0);

    // TX FIFO overflow on ch0 with tx disabled
    wr("t3/ctrl", 0, 2, 16'h00);
    for (int i = 0; i < 17; i++) wr($sformatf("t3/push%0d", i), 0, 0, 16'(i));
    rd_chk("t3/level", 0, 4, 64'h1000);
    rd_chk("t3/status", 0, 1, 64'h98);
    wr("t3/w1c", 0, 1, 16'h80);
    rd_chk("t3/status_clr", 0, 1, 64'h18);

    // frame error on ch0: stop bit 0, byte dropped
    wr("t4/div", 0, 3, 16'd0);
    wr("t4/ctrl", 0, 2, 16'h02);
    send_rx(8'h5A, 1'b0);
    rd_chk("t4/status", 0, 1, 64'h58);
    rd_chk("t4/level", 0, 4, 64'h1000);
    wr("t4/w1c", 0, 1, 16'h40);
    rd_chk("t4/status_clr", 0, 1, 64'h18);

    // RX overrun: 17 bytes into a 16-entry FIFO
    for (int i = 0; i < 17; i++) send_rx(8'h30 + 8'(i), 1'b1);
    rd_chk("t5/status", 0, 1, 64'h3B);
    rd_chk("t5/level", 0, 4, 64'h1010);
    rd_chk("t5/first", 0, 0, 64'h30);

    // data phase stall: addr_req held, data_ack low for 10 cycles
    @(posedge clk); #1;
    addr_req = 1'b1; sel = 1'b1; read = 1'b1; mask = 8'h00;
    addr = {3'b000, 3'd0, 3'd4, 3'b000};
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!addr_ack && n < 20);
    check("t6/ack", {63'h0, addr_ack}, 64'h1);
    cyc(1);
    check("t6/data_req_latency", {63'h0, data_req}, 64'h1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t6/hold%0d", i), {46'h0, addr_ack, data_req, rdata[15:0]},
            {46'h0, 1'b0, 1'b1, 16'h100F});
      cyc(1);
    end
    addr_req = 1'b0;
    data_ack = 1'b1;
    cyc(1);
    data_ack = 1'b0;
    check("t6/release", {63'h0, data_req}, 64'h0);

    // out-of-range channel and unused register
    rd_chk("t7/ch5_div", 5, 3, 64'h0);
    wr("t7/ch5_wr", 5, 3, 16'h1234);
    rd_chk("t7/reg6", 0, 6, 64'h0);

    // reset mid-frame
    wr("t8/div", 0, 3, 16'd3);
    wr("t8/ctrl", 0, 2, 16'h01);
    n = 0;
    while (tx[0] !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("t8/start_seen", {63'h0, tx[0]}, 64'h0);
    cyc(5);
    #3;
    reset_n = 1'b0;
    #1;
    check("t8/tx_async", {62'h0, tx}, 64'h3);
    check("t8/rdata", rdata, 64'h0);
    check("t8/flags", {60'h0, addr_ack, data_req, interrupt, 1'b0}, 64'h0);
    check("t8/rts", {62'h0, rts}, 64'h0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    rd_chk("t8/div", 0, 3, 64'h1A);
    rd_chk("t8/ctrl", 0, 2, 64'h0);
    rd_chk("t8/status", 0, 1, 64'h14);
    rd_chk("t8/level", 0, 4, 64'h0);
    rd_chk("t8/div1", 1, 3, 64'h1A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
